// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and helpers for the RV32M multi-cycle multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN = 32;
    localparam int ITER = 32;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative shift-add multiplier / restoring divider on unsigned magnitudes, with
// combinational sign fix-up and result selection.
module muldiv_core
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      op,
    input  logic            neg_res,
    input  logic            neg_rem,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [XLEN-1:0] res
);

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   opnd;

    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;

    // A 33-bit sum keeps the carry that the right shift moves into the upper word.
    always_comb begin
        add_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : '0);
        shifted = {rem, quot[XLEN-1]};
        diff    = shifted - {1'b0, opnd};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod <= '0;
            quot <= '0;
            rem  <= '0;
            opnd <= '0;
        end else if (load) begin
            prod <= {{XLEN{1'b0}}, a_mag};
            quot <= a_mag;
            rem  <= '0;
            opnd <= b_mag;
        end else if (step) begin
            if (op[2]) begin
                // The borrow bit says whether the trial subtraction went negative.
                if (!diff[XLEN]) begin
                    rem  <= diff[XLEN-1:0];
                    quot <= {quot[XLEN-2:0], 1'b1};
                end else begin
                    rem  <= shifted[XLEN-1:0];
                    quot <= {quot[XLEN-2:0], 1'b0};
                end
            end else begin
                prod <= {add_sum, prod[XLEN-1:1]};
            end
        end
    end

    always_comb begin
        prod_fix = neg_res ? -prod : prod;
        quot_fix = neg_res ? -quot : quot;
        rem_fix  = neg_rem ? -rem  : rem;
        case (op)
            MUL:                 res = prod_fix[XLEN-1:0];
            MULH, MULHSU, MULHU: res = prod_fix[2*XLEN-1:XLEN];
            DIV, DIVU:           res = quot_fix;
            default:             res = rem_fix;
        endcase
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M execute controller: FSM, iteration counter, special-case bypass, stall/done
// and the write-back result register around muldiv_core.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t          state, state_next;
    logic [5:0]      cnt;
    logic [2:0]      op;
    logic            neg_res;
    logic            neg_rem;
    logic            special;
    logic [XLEN-1:0] special_val;
    logic [XLEN-1:0] core_res;

    logic            accept;
    logic            a_signed, b_signed;
    logic            a_neg, b_neg;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;

    assign accept   = start && (state == IDLE || state == DONE);
    assign a_signed = (Funct3 == MULH) || (Funct3 == MULHSU) || (Funct3 == DIV) || (Funct3 == REM);
    assign b_signed = (Funct3 == MULH) || (Funct3 == DIV) || (Funct3 == REM);
    assign a_neg    = a_signed && A[XLEN-1];
    assign b_neg    = b_signed && B[XLEN-1];
    assign a_mag    = magnitude(A, a_neg);
    assign b_mag    = magnitude(B, b_neg);
    assign div_zero = Funct3[2] && (B == '0);
    assign div_ovf  = (Funct3 == DIV || Funct3 == REM) &&
                      (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);

    muldiv_core u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .step    (state == CALC),
        .op      (op),
        .neg_res (neg_res),
        .neg_rem (neg_rem),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .res     (core_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                stall = start;
                done  = (state == DONE);
                if (start) state_next = (div_zero || div_ovf) ? FIX : CALC;
                else       state_next = IDLE;
            end
            CALC: begin
                stall = 1'b1;
                if (flush)                   state_next = IDLE;
                else if (cnt == 6'(ITER-1)) state_next = FIX;
            end
            FIX: begin
                stall      = 1'b1;
                state_next = flush ? IDLE : DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            op          <= '0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            special     <= 1'b0;
            special_val <= '0;
            result      <= '0;
        end else begin
            if (accept) begin
                cnt         <= '0;
                op          <= Funct3;
                neg_res     <= a_neg ^ b_neg;
                neg_rem     <= a_neg;
                special     <= div_zero || div_ovf;
                // Divide-by-zero: all ones or the dividend; overflow: the dividend or zero.
                special_val <= div_zero ? (Funct3[1] ? A : '1) : (Funct3[1] ? '0 : A);
            end else if (state == CALC) begin
                cnt <= cnt + 6'd1;
            end
            if (state == FIX && !flush)
                result <= special ? special_val : core_res;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M vectors, latency, stall,
// flush and asynchronous reset behaviour.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  Funct3;
    logic [31:0] A;
    logic [31:0] B;
    logic        stall;
    logic        done;
    logic [31:0] result;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .Funct3 (Funct3),
        .A      (A),
        .B      (B),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
        int          edge_no;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    localparam int LAT_NORMAL  = 33;
    localparam int LAT_SPECIAL = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_result"}, result, e.exp);
                check({e.name, "_done_edge"}, 32'(cyc), 32'(e.edge_no));
            end
        end
    end

    // Issues one op and returns in its done cycle, so consecutive calls run back-to-back.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int   stall_cycles;
        bit   seen;
        exp_t e;
        stall_cycles = 0;
        seen         = 1'b0;
        Funct3 = f3;
        A      = a;
        B      = b;
        start  = 1'b1;
        e.name    = name;
        e.exp     = exp;
        e.edge_no = cyc + 1 + lat;
        sb_q.push_back(e);
        for (int i = 0; i < 60 && !seen; i++) begin
            #1;
            if (stall) stall_cycles++;
            if (done && i > 0) seen = 1'b1;
            else begin
                @(negedge clk);
                start = 1'b0;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 60 cycles", name);
        end
        check({name, "_stall_cycles"}, 32'(stall_cycles), 32'(lat + 1));
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        Funct3 = '0;
        A      = '0;
        B      = '0;
        repeat (2) @(negedge clk);
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("mul",        MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_NORMAL);
        run_op("mulhu",      MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_NORMAL);
        run_op("mulh",       MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, LAT_NORMAL);
        run_op("mulhsu",     MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, LAT_NORMAL);
        run_op("mulh_min",   MULH,   32'h80000000, 32'h80000000, 32'h40000000, LAT_NORMAL);
        run_op("div_neg",    DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT_NORMAL);
        run_op("rem_neg",    REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_NORMAL);
        run_op("div_negb",   DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, LAT_NORMAL);
        run_op("rem_negb",   REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, LAT_NORMAL);
        run_op("divu",       DIVU,   32'd100,      32'd7,        32'd14,       LAT_NORMAL);
        run_op("remu",       REMU,   32'd100,      32'd7,        32'd2,        LAT_NORMAL);
        run_op("divu_zero",  DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, LAT_SPECIAL);
        run_op("remu_zero",  REMU,   32'd5,        32'd0,        32'd5,        LAT_SPECIAL);
        run_op("div_zero",   DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, LAT_SPECIAL);
        run_op("rem_zero",   REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, LAT_SPECIAL);
        run_op("div_ovf",    DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_SPECIAL);
        run_op("rem_ovf",    REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_SPECIAL);
        run_op("divu_noovf", DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_NORMAL);
        run_op("remu_noovf", REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_NORMAL);

        // Result must hold once the unit goes idle.
        repeat (3) @(negedge clk);
        check("result_hold", result, 32'h80000000);

        // Flush mid-CALC: back to idle, no done, result untouched.
        Funct3 = DIV;
        A      = 32'd100;
        B      = 32'd7;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #1 check("flush_pre_stall", {31'b0, stall}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1 check("flush_stall", {31'b0, stall}, 32'd0);
        check("flush_done", {31'b0, done}, 32'd0);
        check("flush_result", result, 32'h80000000);
        repeat (40) @(negedge clk);
        check("flush_no_done", {31'b0, done}, 32'd0);
        run_op("after_flush", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LAT_NORMAL);

        // Asynchronous reset between edges in the middle of CALC.
        @(negedge clk);
        Funct3 = MULHU;
        A      = 32'h12345678;
        B      = 32'h9ABCDEF0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("arst_stall", {31'b0, stall}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("after_rst", MUL, 32'd1000, 32'd1000, 32'd1000000, LAT_NORMAL);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
